// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO over a reset-clearable register array, with count-decoded
// status flags, sticky over/underflow and selectable registered or FWFT output.
module sync_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          FWFT       = 1'b0,
    parameter int unsigned AF_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  Write_EN,
    input  logic                  Read_EN,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned        DEPTH   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    assign w_full    = (r_count == C_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_wr_acc  = Write_EN && !w_full && !flush;
    assign w_rd_acc  = Read_EN && !w_empty && !flush;
    assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
    assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_acc) begin
            r_mem[w_wr_addr] <= DataIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_ONE;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_ONE;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
            if (Write_EN && w_full)  r_overflow  <= 1'b1;
            if (Read_EN  && w_empty) r_underflow <= 1'b1;
        end
    end

    // Pointer MSBs carry the wrap lap; occupancy must always equal their distance.
    always_comb begin
        assert (r_count == (r_wr_ptr - r_rd_ptr));
    end

    generate
        if (FWFT) begin : g_fwft
            assign DataOut = r_mem[w_rd_addr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_dout;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    r_dout <= r_mem[w_rd_addr];
                end
            end
            assign DataOut = r_dout;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AF);
    assign almost_empty = (r_count <= C_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Scoreboard bench driving a registered-output and an FWFT instance in lockstep.
module tb_sync_fifo_ram;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic [7:0] din = '0;

    logic [7:0] dout0, dout1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [5:0] count0, count1;

    sync_fifo_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .FWFT(1'b0)) u_dut_reg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .Write_EN(we), .Read_EN(re),
        .DataIn(din), .DataOut(dout0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .FWFT(1'b1)) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .Write_EN(we), .Read_EN(re),
        .DataIn(din), .DataOut(dout1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    always #5 clk = ~clk;

    logic [7:0] mmem [DEPTH];
    int         m_wp = 0, m_rp = 0, m_cnt = 0;
    bit         m_ovf = 0, m_unf = 0;
    logic [7:0] exp_q [$];
    bit         exp_fire = 0;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".count"},     int'(count0), m_cnt);
        chk({tag, ".full"},      int'(full0),  int'(m_cnt == DEPTH));
        chk({tag, ".empty"},     int'(empty0), int'(m_cnt == 0));
        chk({tag, ".afull"},     int'(af0),    int'(m_cnt >= DEPTH - 2));
        chk({tag, ".aempty"},    int'(ae0),    int'(m_cnt <= 2));
        chk({tag, ".overflow"},  int'(ovf0),   int'(m_ovf));
        chk({tag, ".underflow"}, int'(unf0),   int'(m_unf));
        chk({tag, ".fwft_count"}, int'(count1), m_cnt);
        chk({tag, ".fwft_empty"}, int'(empty1), int'(m_cnt == 0));
        chk({tag, ".fwft_flags"}, int'({af1, ae1, ovf1, unf1, full1}),
            int'({m_cnt >= DEPTH - 2, m_cnt <= 2, m_ovf, m_unf, m_cnt == DEPTH}));
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        m_wp = 0; m_rp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
        exp_fire = 0;
    endtask

    // Called at posedge+1; drives one cycle and advances the model at the edge.
    task automatic cycle(input bit w, input bit r, input logic [7:0] d, input bit f = 1'b0);
        bit wa, ra;
        we = w; re = r; din = d; flush = f;
        exp_fire = r && (m_cnt != 0) && !f;
        @(posedge clk);
        if (f) begin
            m_wp = 0; m_rp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
        end else begin
            wa = w && (m_cnt != DEPTH);
            ra = r && (m_cnt != 0);
            if (w && m_cnt == DEPTH) m_ovf = 1;
            if (r && m_cnt == 0)     m_unf = 1;
            if (ra) exp_q.push_back(mmem[m_rp % DEPTH]);
            if (wa) begin
                mmem[m_wp % DEPTH] = d;
                m_wp = (m_wp + 1) % (2 * DEPTH);
            end
            if (ra) m_rp = (m_rp + 1) % (2 * DEPTH);
            m_cnt = m_cnt + int'(wa) - int'(ra);
        end
        #1;
        we = 0; re = 0; flush = 0; exp_fire = 0;
    endtask

    initial begin : monitor
        bit fire;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            fire = exp_fire;
            @(negedge clk);
            if (fire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_data actual=0x%0h expected=<none queued>", dout0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", int'(dout0), int'(e));
                end
            end
            if (m_cnt != 0) chk("fwft_head", int'(dout1), int'(mmem[m_rp % DEPTH]));
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : stim
        model_reset();
        #12;
        check_status("reset");
        chk("reset.dout_reg",  int'(dout0), 0);
        chk("reset.dout_fwft", int'(dout1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            check_status("fill");
        end

        cycle(1'b1, 1'b0, 8'hAA);
        check_status("write_full");

        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check_status("drain");
        end

        cycle(1'b1, 1'b1, 8'h5C);
        check_status("read_empty");
        chk("fwft_first", int'(dout1), 8'h5C);

        cycle(1'b1, 1'b0, 8'h5D);
        cycle(1'b1, 1'b0, 8'h5E);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h60 + i));
            check_status("stream");
        end

        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i));
        check_status("pre_flush");
        cycle(1'b1, 1'b0, 8'hEE, 1'b1);
        check_status("flush");

        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h90 + i));
        we = 1'b1;
        din = 8'h94;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_status("async_rst");
        chk("async_rst.dout_reg",  int'(dout0), 0);
        chk("async_rst.dout_fwft", int'(dout1), 0);
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
        check_status("refill");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);
        check_status("final_drain");
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        chk("scoreboard_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
